// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and default 1024x768 timing constants.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_state_e;

  localparam int DEF_COUNTER_SIZE = 11;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FRONT  = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_LAST   = 1328;

  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FRONT  = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_LAST   = 805;

  // Sync window bounds: sync is [SYNC_START, SYNC_END)
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_axis_decoder.sv
// One timing axis: decodes a raw count into a registered ACTIVE/FRONT/SYNC/BACK state.
module vga_axis_decoder
  import vga_timing_pkg::*;
#(
  parameter int COUNTER_SIZE = DEF_COUNTER_SIZE,
  parameter int ACT          = DEF_H_ACTIVE,
  parameter int FRONT        = DEF_H_FRONT,
  parameter int SYNC         = DEF_H_SYNC,
  parameter int LAST         = DEF_H_LAST
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [COUNTER_SIZE-1:0] count,
  output axis_state_e             state,
  output logic                    in_active,
  output logic                    in_sync,
  output logic                    at_last
);

  localparam logic [COUNTER_SIZE-1:0] ACT_C        = COUNTER_SIZE'(ACT);
  localparam logic [COUNTER_SIZE-1:0] SYNC_START_C = COUNTER_SIZE'(ACT + FRONT);
  localparam logic [COUNTER_SIZE-1:0] SYNC_END_C   = COUNTER_SIZE'(ACT + FRONT + SYNC);
  localparam logic [COUNTER_SIZE-1:0] LAST_C       = COUNTER_SIZE'(LAST);

  axis_state_e state_next;

  // Region decode; LAST and anything beyond it (upstream wrap) fall into BACK
  always_comb begin
    state_next = state;
    if (enable) begin
      if (count >= LAST_C)            state_next = ST_BACK;
      else if (count < ACT_C)         state_next = ST_ACTIVE;
      else if (count < SYNC_START_C)  state_next = ST_FRONT;
      else if (count < SYNC_END_C)    state_next = ST_SYNC;
      else                            state_next = ST_BACK;
    end
  end

  // State register; reset parks the axis in BACK (sync off, video off)
  always_ff @(posedge clk) begin
    if (reset) state <= ST_BACK;
    else       state <= state_next;
  end

  assign in_active = (state == ST_ACTIVE);
  assign in_sync   = (state == ST_SYNC);
  // Unregistered: the top registers the pulse it derives from this
  assign at_last   = (count == LAST_C);

endmodule

// File: rtl/vga_sync_generator.sv
// VGA sync/timing stage: turns raw h/v counts into registered sync, video and pixel coords.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int COUNTER_SIZE      = DEF_COUNTER_SIZE,
  parameter int H_ACTIVE          = DEF_H_ACTIVE,
  parameter int H_FRONT           = DEF_H_FRONT,
  parameter int H_SYNC            = DEF_H_SYNC,
  parameter int H_LAST            = DEF_H_LAST,
  parameter int V_ACTIVE          = DEF_V_ACTIVE,
  parameter int V_FRONT           = DEF_V_FRONT,
  parameter int V_SYNC            = DEF_V_SYNC,
  parameter int V_LAST            = DEF_V_LAST,
  parameter bit SYNC_ACTIVE_LEVEL = 1'b0
) (
  input  logic                    control_clock,
  input  logic                    control_reset,
  input  logic                    pixel_enable,
  input  logic [COUNTER_SIZE-1:0] h_count,
  input  logic [COUNTER_SIZE-1:0] v_count,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    video_on,
  output logic [COUNTER_SIZE-1:0] pixel_x,
  output logic [COUNTER_SIZE-1:0] pixel_y,
  output logic                    line_end,
  output logic                    frame_start
);

  axis_state_e             h_state, v_state;
  logic                    h_in_active, v_in_active;
  logic                    h_in_sync, v_in_sync;
  logic                    h_at_last, v_at_last;
  logic [COUNTER_SIZE-1:0] h_q, v_q;

  vga_axis_decoder #(
    .COUNTER_SIZE(COUNTER_SIZE), .ACT(H_ACTIVE), .FRONT(H_FRONT),
    .SYNC(H_SYNC), .LAST(H_LAST)
  ) u_h_axis (
    .clk(control_clock), .reset(control_reset), .enable(pixel_enable),
    .count(h_count), .state(h_state), .in_active(h_in_active),
    .in_sync(h_in_sync), .at_last(h_at_last)
  );

  vga_axis_decoder #(
    .COUNTER_SIZE(COUNTER_SIZE), .ACT(V_ACTIVE), .FRONT(V_FRONT),
    .SYNC(V_SYNC), .LAST(V_LAST)
  ) u_v_axis (
    .clk(control_clock), .reset(control_reset), .enable(pixel_enable),
    .count(v_count), .state(v_state), .in_active(v_in_active),
    .in_sync(v_in_sync), .at_last(v_at_last)
  );

  // Capture counts alongside the axis states; pulses are recomputed every enabled cycle
  always_ff @(posedge control_clock) begin
    if (control_reset) begin
      h_q         <= '0;
      v_q         <= '0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (pixel_enable) begin
        h_q <= h_count;
        v_q <= v_count;
      end
      line_end    <= pixel_enable & h_at_last;
      frame_start <= pixel_enable & h_at_last & v_at_last;
    end
  end

  assign hsync    = h_in_sync ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
  assign vsync    = v_in_sync ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
  assign video_on = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
  // Coordinates only exist inside the visible area
  assign pixel_x  = (h_in_active && v_in_active) ? h_q : '0;
  assign pixel_y  = (h_in_active && v_in_active) ? v_q : '0;

endmodule

// File: doc/vga_sync_generator.md
Name: vga_sync_generator

Overview:
Downstream stage of the free-running horizontal and vertical pixel counters. It consumes the raw horizontal and vertical count values and produces registered VGA timing: hsync, vsync, video_on, and the active-area pixel coordinates. It also drives the end-of-line enable that advances the vertical counter, and a frame-start strobe for the pixel-generation logic. Default timing is 1024x768 with a horizontal last count of 1328 and a vertical last count of 805.

Parameters:
COUNTER_SIZE, 11, width of h_count / v_count / pixel_x / pixel_y
H_ACTIVE, 1024, visible pixels per line
H_FRONT, 24, horizontal front porch length
H_SYNC, 136, horizontal sync pulse length
H_LAST, 1328, h_count value that ends a line
V_ACTIVE, 768, visible lines per frame
V_FRONT, 3, vertical front porch length
V_SYNC, 6, vertical sync pulse length
V_LAST, 805, v_count value that ends a frame
SYNC_ACTIVE_LEVEL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
control_clock  input  1  pixel clock
control_reset  input  1  synchronous, active-high reset
pixel_enable  input  1  advance/update qualifier; outputs hold when low
h_count  input  COUNTER_SIZE  horizontal count from the upstream counter
v_count  input  COUNTER_SIZE  vertical count from the upstream counter
hsync  output  1  horizontal sync, registered
vsync  output  1  vertical sync, registered
video_on  output  1  high inside the active area, registered
pixel_x  output  COUNTER_SIZE  active-area column, 0 outside the active area
pixel_y  output  COUNTER_SIZE  active-area row, 0 outside the active area
line_end  output  1  one-cycle pulse at end of line; drives the vertical counter's enable
frame_start  output  1  one-cycle pulse at end of the final line of the frame

Behaviour:
- All logic is synchronous to control_clock. Reset is synchronous and active-high and takes priority over pixel_enable.
- Reset values:
  - hsync = vsync = ~SYNC_ACTIVE_LEVEL
  - video_on = 0, pixel_x = 0, pixel_y = 0
  - line_end = 0, frame_start = 0
  - both axis FSMs in BACK
- Each axis has a 4-state FSM: ACTIVE, FRONT, SYNC, BACK. The next state is decoded from the count on each enabled cycle:
  - ACTIVE when count < ACT
  - FRONT when ACT <= count < ACT+FRONT
  - SYNC when ACT+FRONT <= count < ACT+FRONT+SYNC
  - BACK otherwise, including count == LAST and any count > LAST
- Out-of-range counts therefore force BACK, which keeps sync deasserted and video off. This covers the upstream wrap cycle.
- Latency: every output reflects the counts sampled 1 cycle earlier (single register stage).
- hsync = SYNC_ACTIVE_LEVEL iff H state is SYNC. vsync = SYNC_ACTIVE_LEVEL iff V state is SYNC.
- video_on = (H state ACTIVE) and (V state ACTIVE).
- pixel_x = h_count and pixel_y = v_count when video_on is asserted in the same registered cycle; both are 0 otherwise.
- line_end = 1 for exactly one cycle when the sampled h_count == H_LAST and pixel_enable = 1.
- frame_start = 1 for exactly one cycle when line_end is asserted and the sampled v_count == V_LAST.
- pixel_enable = 0: all registers hold, and line_end / frame_start are forced to 0 (pulses are not stretched).
- Reset mid-line: outputs return to reset values on the next edge. Decoding resumes from the incoming counts on the first enabled cycle after reset deasserts; no re-synchronisation wait.
- No arithmetic overflow: the comparison constants are computed at elaboration and must fit in COUNTER_SIZE bits.

Decomposition:
- Package vga_timing_pkg holds:
  - the axis state enum {ACTIVE, FRONT, SYNC, BACK}
  - the default 1024x768 timing constants
  - derived boundary constants (ACT+FRONT, ACT+FRONT+SYNC)
- One sub-module, vga_axis_decoder, is instantiated twice (horizontal and vertical).
  - Parameters: ACT, FRONT, SYNC, LAST.
  - Inputs: count, enable, reset.
  - Outputs: registered state, in_active, in_sync, at_last.
- The top level combines the two decoders and registers pixel_x, pixel_y, line_end and frame_start.

Test Plan:
1. Reset asserted with h=500, v=10, then released with pixel_enable=1 -> during reset hsync=vsync=1, video_on=0; the cycle after release gives video_on=1, pixel_x=500, pixel_y=10.
2. h sweep 1022, 1023, 1024 with v=0 -> video_on 1, 1, 0 with 1-cycle lag; pixel_x 1022, 1023, then 0.
3. h = 1047, 1048, 1183, 1184 -> hsync 1, 0, 0, 1 (active-low, 1-cycle lag).
4. h=1328 with v=100, then h=1328 with v=805 -> first gives line_end=1 and frame_start=0; second gives line_end=1 and frame_start=1; both pulses last exactly one cycle.
5. v = 770, 771, 776, 777 with h=0 -> vsync 1, 0, 0, 1; video_on=0 throughout.
6. h=1328 held with pixel_enable=0 for 3 cycles, then pixel_enable=1 -> line_end stays 0 while disabled and pulses once after enable; h=2000 -> BACK, hsync=1, video_on=0.
